proj_minhash_sig: RTL and testbench
===================================

Name: proj_minhash_sig

Overview:
- Downstream consumer of the projection feature-map RAM.
- Takes one CHUNK_SIZE-element chunk per valid cycle from the RAM read port and hashes every element with NUM_HASHES independent linear hash functions.
- Tracks a running minimum per hash across SET_CHUNKS consecutive chunks.
- At the end of each set, emits a NUM_HASHES-entry MinHash signature with a one-cycle valid pulse.

Parameters:
- CHUNK_SIZE, 2, elements per input chunk (matches the RAM's CHUNK_SIZE)
- DATA_BITS, 8, bits per element
- NUM_HASHES, 4, number of hash functions / signature entries
- HASH_BITS, 16, width of each hash value and signature entry
- SET_CHUNKS, 4, chunks per set (one signature per SET_CHUNKS accepted chunks)

Ports:
- in_clk  input  1  clock, all logic on the rising edge
- in_rst_n  input  1  asynchronous active-low reset
- in_rdata  input  CHUNK_SIZE*DATA_BITS  chunk from the RAM; element j is bits [j*DATA_BITS +: DATA_BITS]
- in_valid  input  1  chunk qualifier; no backpressure, so the chunk is accepted on every edge where it is high
- in_clear  input  1  synchronous abort of the current set
- out_sig  output  NUM_HASHES*HASH_BITS  signature; entry k is bits [k*HASH_BITS +: HASH_BITS]
- out_valid  output  1  one-cycle pulse, high when out_sig holds a new signature
- out_busy  output  1  high while a set is partially accumulated or the pipeline holds data

Behaviour:
- Reset (async assert, sync release):
  - out_sig=0, out_valid=0, out_busy=0.
  - Chunk counter, stage valids and running minima are cleared.
  - A partial set is discarded.
- Hash function: h_k(x) = (HASH_A[k]*x + HASH_B[k]) mod 2^HASH_BITS.
  - x is zero-extended; the product is computed at full width, then truncated.
- Stage 1, on an accepted chunk:
  - Register h_k of every element.
  - s1_first is set when chunk_cnt==0; s1_last is set when chunk_cnt==SET_CHUNKS-1.
  - chunk_cnt increments, wrapping from SET_CHUNKS-1 to 0.
- Stage 2, when s1_valid:
  - cmin_k = min over j of the stage-1 hashes, unsigned compare.
  - run_k <= s1_first ? cmin_k : min(run_k, cmin_k).
  - If s1_last: out_sig entry k <= that same result, and out_valid=1 for exactly one cycle.
- Latency: if the last chunk of a set is sampled at edge t, out_valid is high for the cycle following edge t+1.
- out_sig holds its value until the next signature, clear, or reset.
- Back-to-back sets are allowed: chunk 0 of the next set may arrive the cycle after the last chunk of the previous set, with no bubble.
- in_valid low leaves chunk_cnt and run_k unchanged; gaps inside a set are legal.
- in_clear:
  - Takes priority over an in_valid on the same edge; that chunk is dropped.
  - Zeroes chunk_cnt, s1_valid and s2 state; no out_valid is produced for the aborted set.
  - out_sig keeps its last value.
- out_busy = (chunk_cnt!=0) | s1_valid.
- Min ties: equal values give the same result, so no tie rule is needed.
- SET_CHUNKS=1: every chunk is both first and last, giving one signature per chunk.
- The control state is implicit (IDLE when chunk_cnt==0 and no stage valid, else ACCUM); no separate FSM register.

Decomposition:
- Package proj_minhash_pkg holds:
  - HASH_A and HASH_B constant arrays, NUM_HASHES entries of HASH_BITS, defaults A={3,5,7,11}, B={1,2,3,4}
  - the hash_t typedef
  - the function hash_fn(k, x)
- Sub-module proj_minhash_min: combinational unsigned min-reduction tree over CHUNK_SIZE+1 HASH_BITS inputs, instantiated once per hash.

Test Plan:
- Reset mid-set: feed 2 chunks, assert in_rst_n=0 -> outputs 0; then feed 4 new chunks -> exactly one out_valid, computed only from post-reset data.
- Basic set: chunks {1,0},{3,2},{5,4},{7,6} on consecutive cycles (x=0 present) -> one out_valid 2 edges after the last chunk; out_sig = {4,3,2,1} (entry 3..0).
- Back-to-back sets: set A as above, then set B of elements 10..17 with no gap -> two pulses 4 cycles apart; set B sig = {114,73,52,31}.
- Gaps and clear: set with in_valid low for 3 cycles mid-set -> same signature as gapless; in_clear on the edge carrying chunk 3 -> no pulse, out_sig unchanged, out_busy=0 next cycle.
- Truncation (HASH_BITS=8 override): single set of all-100 elements -> entry 0 = 301 mod 256 = 45, entry 3 = 1104 mod 256 = 80.
- Random regression: 1000 random sets with random valid gaps, checked against a scoreboard model of min over hash_fn.

Source files
------------

// File: rtl/proj_minhash_pkg.sv
// Hash constants, types and the linear hash helper shared by the
// MinHash signature block.
package proj_minhash_pkg;

    localparam int HASH_W   = 32;
    localparam int HASH_NUM = 4;

    // Full-width hash word; callers truncate to their own HASH_BITS.
    typedef logic [HASH_W-1:0] hash_t;
    typedef logic [$clog2(HASH_NUM)-1:0] hidx_t;

    localparam hash_t HASH_A [HASH_NUM] = '{32'd3, 32'd5, 32'd7, 32'd11};
    localparam hash_t HASH_B [HASH_NUM] = '{32'd1, 32'd2, 32'd3, 32'd4};

    function automatic hash_t hash_fn(input hidx_t k, input hash_t x);
        return HASH_A[k] * x + HASH_B[k];
    endfunction

endpackage

// File: rtl/proj_minhash_min.sv
// Combinational unsigned minimum over N packed W-bit values.
// Entry i occupies bits [i*W +: W].
module proj_minhash_min #(
    parameter int N = 3,
    parameter int W = 16
) (
    input  logic [N*W-1:0] vals,
    output logic [W-1:0]   result
);

    always_comb begin
        result = vals[W-1:0];
        for (int i = 1; i < N; i++) begin
            if (vals[i*W +: W] < result) begin
                result = vals[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/proj_minhash_sig.sv
// MinHash signature generator: hashes each chunk element, keeps a running
// per-hash minimum over SET_CHUNKS chunks and emits one signature per set.
module proj_minhash_sig #(
    parameter int CHUNK_SIZE = 2,
    parameter int DATA_BITS  = 8,
    parameter int NUM_HASHES = 4,
    parameter int HASH_BITS  = 16,
    parameter int SET_CHUNKS = 4
) (
    input  logic                             in_clk,
    input  logic                             in_rst_n,
    input  logic [CHUNK_SIZE*DATA_BITS-1:0]  in_rdata,
    input  logic                             in_valid,
    input  logic                             in_clear,
    output logic [NUM_HASHES*HASH_BITS-1:0]  out_sig,
    output logic                             out_valid,
    output logic                             out_busy
);

    import proj_minhash_pkg::*;

    localparam int CW = (SET_CHUNKS > 1) ? $clog2(SET_CHUNKS) : 1;

    typedef logic [NUM_HASHES-1:0][CHUNK_SIZE-1:0][HASH_BITS-1:0] chunk_hash_t;
    typedef logic [NUM_HASHES-1:0][HASH_BITS-1:0] sig_t;

    logic [CW-1:0] chunk_cnt;
    logic          cnt_first;
    logic          cnt_last;

    chunk_hash_t   h_in;
    chunk_hash_t   s1_hash;
    logic          s1_valid;
    logic          s1_first;
    logic          s1_last;

    sig_t          run;
    sig_t          res;

    assign cnt_first = (chunk_cnt == '0);
    assign cnt_last  = (chunk_cnt == CW'(SET_CHUNKS - 1));
    assign out_busy  = (chunk_cnt != '0) | s1_valid;

    always_comb begin
        h_in = '0;
        for (int k = 0; k < NUM_HASHES; k++) begin
            for (int j = 0; j < CHUNK_SIZE; j++) begin
                h_in[k][j] = HASH_BITS'(hash_fn(hidx_t'(k),
                    hash_t'(in_rdata[j*DATA_BITS +: DATA_BITS])));
            end
        end
    end

    // On the first chunk of a set the running minimum is replaced by
    // all-ones so the reduction yields the chunk minimum alone.
    for (genvar k = 0; k < NUM_HASHES; k++) begin : g_min
        proj_minhash_min #(
            .N (CHUNK_SIZE + 1),
            .W (HASH_BITS)
        ) u_min (
            .vals   ({s1_hash[k], s1_first ? {HASH_BITS{1'b1}} : run[k]}),
            .result (res[k])
        );
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            chunk_cnt <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_hash   <= '0;
            run       <= '0;
            out_sig   <= '0;
            out_valid <= 1'b0;
        end else if (in_clear) begin
            chunk_cnt <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            run       <= '0;
            out_valid <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid & s1_last;
            if (in_valid) begin
                s1_hash   <= h_in;
                s1_first  <= cnt_first;
                s1_last   <= cnt_last;
                chunk_cnt <= cnt_last ? '0 : chunk_cnt + 1'b1;
            end
            if (s1_valid) begin
                run <= res;
                if (s1_last) begin
                    out_sig <= res;
                end
            end
        end
    end

endmodule

// File: tb/tb_proj_minhash_sig.sv
// Directed and scoreboard-checked bench for proj_minhash_sig, with a
// second 8-bit-hash instance for the truncation case.
module tb_proj_minhash_sig;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] rdata;
    logic        valid;
    logic        clear;

    logic [63:0] sig;
    logic        sig_valid;
    logic        busy;
    logic [31:0] sig8;
    logic        valid8;
    logic        busy8;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_cyc = 0;

    logic [63:0] sig_q[$];
    int          pcyc_q[$];
    logic [63:0] exp_q[$];

    localparam logic [63:0] SIG_A = 64'h0004_0003_0002_0001;
    localparam logic [63:0] SIG_B = 64'h0072_0049_0034_001F;
    localparam logic [63:0] SIG_C = 64'h00E0_008F_0066_003D;

    proj_minhash_sig dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .in_rdata (rdata),
        .in_valid (valid),
        .in_clear (clear),
        .out_sig  (sig),
        .out_valid(sig_valid),
        .out_busy (busy)
    );

    proj_minhash_sig #(.HASH_BITS(8)) dut8 (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .in_rdata (rdata),
        .in_valid (valid),
        .in_clear (clear),
        .out_sig  (sig8),
        .out_valid(valid8),
        .out_busy (busy8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sig_valid) begin
            sig_q.push_back(sig);
            pcyc_q.push_back(cyc);
        end
    end

    task automatic expect_eq(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d,
                         input logic c, input logic last);
        @(negedge clk);
        valid = v;
        rdata = d;
        clear = c;
        if (last) last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic send4(input logic [15:0] c0, c1, c2, c3);
        drive(1'b1, c0, 1'b0, 1'b0);
        drive(1'b1, c1, 1'b0, 1'b0);
        drive(1'b1, c2, 1'b0, 1'b0);
        drive(1'b1, c3, 1'b0, 1'b1);
    endtask

    task automatic flush_q();
        sig_q.delete();
        pcyc_q.delete();
    endtask

    function automatic logic [15:0] model_h(input int k, input logic [7:0] x);
        int unsigned a;
        int unsigned b;
        case (k)
            0: begin a = 3;  b = 1; end
            1: begin a = 5;  b = 2; end
            2: begin a = 7;  b = 3; end
            default: begin a = 11; b = 4; end
        endcase
        return 16'(a * x + b);
    endfunction

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        rdata = '0;
        clear = 1'b0;
        repeat (2) @(negedge clk);
        expect_eq("rst_sig", sig, 64'h0);
        expect_eq("rst_valid", 64'(sig_valid), 64'h0);
        expect_eq("rst_busy", 64'(busy), 64'h0);
        expect_eq("rst_sig8", 64'(sig8), 64'h0);
        rst_n = 1'b1;

        // reset in the middle of a set
        drive(1'b1, 16'h0100, 1'b0, 1'b0);
        drive(1'b1, 16'h0302, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        expect_eq("mid_busy", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        expect_eq("mid_rst_busy", 64'(busy), 64'h0);
        expect_eq("mid_rst_valid", 64'(sig_valid), 64'h0);
        expect_eq("mid_rst_sig", sig, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        flush_q();
        send4(16'h1514, 16'h1716, 16'h1918, 16'h1b1a);
        idle(5);
        expect_eq("post_rst_cnt", 64'(sig_q.size()), 64'd1);
        expect_eq("post_rst_sig", sig_q.size() > 0 ? sig_q[0] : 64'hx, SIG_C);

        // basic set and latency
        flush_q();
        send4(16'h0100, 16'h0302, 16'h0504, 16'h0706);
        @(negedge clk);
        valid = 1'b0;
        expect_eq("basic_busy_tail", 64'(busy), 64'h1);
        idle(4);
        expect_eq("basic_cnt", 64'(sig_q.size()), 64'd1);
        expect_eq("basic_sig", sig_q.size() > 0 ? sig_q[0] : 64'hx, SIG_A);
        expect_eq("basic_lat", 64'(pcyc_q.size() > 0 ? pcyc_q[0] - last_cyc : -1),
                  64'd2);
        expect_eq("basic_idle_busy", 64'(busy), 64'h0);
        expect_eq("basic_hold", sig, SIG_A);

        // back-to-back sets
        flush_q();
        send4(16'h0100, 16'h0302, 16'h0504, 16'h0706);
        send4(16'h0b0a, 16'h0d0c, 16'h0f0e, 16'h1110);
        idle(5);
        expect_eq("b2b_cnt", 64'(sig_q.size()), 64'd2);
        expect_eq("b2b_sig_a", sig_q.size() > 0 ? sig_q[0] : 64'hx, SIG_A);
        expect_eq("b2b_sig_b", sig_q.size() > 1 ? sig_q[1] : 64'hx, SIG_B);
        expect_eq("b2b_gap", 64'(pcyc_q.size() > 1 ? pcyc_q[1] - pcyc_q[0] : -1),
                  64'd4);

        // gaps inside a set
        flush_q();
        drive(1'b1, 16'h0100, 1'b0, 1'b0);
        drive(1'b1, 16'h0302, 1'b0, 1'b0);
        idle(3);
        expect_eq("gap_busy", 64'(busy), 64'h1);
        drive(1'b1, 16'h0504, 1'b0, 1'b0);
        drive(1'b1, 16'h0706, 1'b0, 1'b1);
        idle(5);
        expect_eq("gap_cnt", 64'(sig_q.size()), 64'd1);
        expect_eq("gap_sig", sig_q.size() > 0 ? sig_q[0] : 64'hx, SIG_A);

        // clear on the edge carrying chunk 3
        flush_q();
        drive(1'b1, 16'h0b0a, 1'b0, 1'b0);
        drive(1'b1, 16'h0d0c, 1'b0, 1'b0);
        drive(1'b1, 16'h0f0e, 1'b0, 1'b0);
        drive(1'b1, 16'h1110, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        expect_eq("clr_busy", 64'(busy), 64'h0);
        idle(5);
        expect_eq("clr_cnt", 64'(sig_q.size()), 64'd0);
        expect_eq("clr_sig_hold", sig, SIG_A);
        send4(16'h1514, 16'h1716, 16'h1918, 16'h1b1a);
        idle(5);
        expect_eq("clr_next_cnt", 64'(sig_q.size()), 64'd1);
        expect_eq("clr_next_sig", sig_q.size() > 0 ? sig_q[0] : 64'hx, SIG_C);

        // truncation of the full product
        flush_q();
        send4(16'h6464, 16'h6464, 16'h6464, 16'h6464);
        idle(5);
        expect_eq("trunc_sig16", sig, 64'h0450_02BF_01F6_012D);
        expect_eq("trunc_sig8", 64'(sig8), 64'h50BF_F62D);

        // scoreboard regression with random gaps
        flush_q();
        exp_q.delete();
        for (int s = 0; s < 1000; s++) begin
            logic [63:0] e;
            logic [15:0] ch [4];
            logic [15:0] mn;
            for (int i = 0; i < 4; i++) ch[i] = 16'($urandom);
            e = '0;
            for (int k = 0; k < 4; k++) begin
                mn = 16'hFFFF;
                for (int i = 0; i < 4; i++) begin
                    if (model_h(k, ch[i][7:0]) < mn) mn = model_h(k, ch[i][7:0]);
                    if (model_h(k, ch[i][15:8]) < mn) mn = model_h(k, ch[i][15:8]);
                end
                e[k*16 +: 16] = mn;
            end
            exp_q.push_back(e);
            for (int i = 0; i < 4; i++) begin
                drive(1'b1, ch[i], 1'b0, i == 3);
                if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(5);
        expect_eq("rand_cnt", 64'(sig_q.size()), 64'(exp_q.size()));
        for (int s = 0; s < exp_q.size(); s++) begin
            expect_eq($sformatf("rand_%0d", s),
                      s < sig_q.size() ? sig_q[s] : 64'hx, exp_q[s]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
